// File: rtl/coin_acceptor_if.sv
// Coin-acceptor bus: raw sensor levels and downstream hold in, clean coin
// codes and status out.
interface coin_acceptor_if;
  // Handshake: coin is a one-cycle pulse whenever it is nonzero. hold acts as
  // an inverted ready. While hold=1 nothing is emitted and queued coins are
  // kept. Emission resumes on the first edge that samples hold=0.
  logic       sense5;
  logic       sense10;
  logic       hold;
  logic [1:0] coin;
  logic       reject;
  logic       jam;
  logic [1:0] pending;

  modport master (
    output sense5, sense10, hold,
    input  coin, reject, jam, pending
  );

  modport slave (
    input  sense5, sense10, hold,
    output coin, reject, jam, pending
  );
endinterface

// File: rtl/coin_acceptor.sv
// Coin front end: synchronise and debounce two coin sensors, detect jams, and
// queue up to two coin codes for the vending controller behind a hold signal.
module coin_acceptor #(
  parameter int DEB_CYCLES = 4,
  parameter int JAM_CYCLES = 64
) (
  input  logic           clk,
  input  logic           reset,
  coin_acceptor_if.slave bus,
  output logic [1:0]     dbg_state5,
  output logic [1:0]     dbg_state10
);
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int JW = $clog2(JAM_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [JW-1:0] JAM_LAST = JW'(JAM_CYCLES - 1);
  localparam logic [JW-1:0] JAM_MAX  = JW'(JAM_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMING  = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } ch_state_t;

  // Channel index 0 is the 5-unit sensor, index 1 the 10-unit sensor.
  logic [1:0] sync1;
  logic [1:0] sync_s;

  ch_state_t       state_q [2];
  ch_state_t       state_d [2];
  logic [CW-1:0]   cnt_q   [2];
  logic [CW-1:0]   cnt_d   [2];
  logic [JW-1:0]   jcnt_q  [2];
  logic [JW-1:0]   jcnt_d  [2];
  logic [1:0]      ev;
  logic [1:0]      jam_hit;

  logic [1:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count_q;

  logic       coin_q;
  logic [1:0] coin_code_q;
  logic       reject_q;
  logic       jam_q;

  logic       both_ev;
  logic       any_ev;
  logic [1:0] ev_code;
  logic       pop;
  logic       full;
  logic       drop;
  logic       push;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 2'b00;
      sync_s <= 2'b00;
    end else begin
      sync1  <= {bus.sense10, bus.sense5};
      sync_s <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        jcnt_q[i]  <= '0;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        jcnt_q[i]  <= jcnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      jcnt_d[i]  = jcnt_q[i];
      ev[i]      = 1'b0;
      jam_hit[i] = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (sync_s[i]) begin
            state_d[i] = ARMING;
            cnt_d[i]   = CW'(1);
          end
        end
        ARMING: begin
          if (!sync_s[i]) begin
            state_d[i] = IDLE;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = ACTIVE;
            ev[i]      = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        ACTIVE: begin
          if (!sync_s[i]) begin
            state_d[i] = RELEASE;
            cnt_d[i]   = CW'(1);
          end else begin
            // Saturate so a permanently stuck sensor cannot wrap the counter.
            if (jcnt_q[i] != JAM_MAX) jcnt_d[i] = jcnt_q[i] + JW'(1);
            if (jcnt_q[i] == JAM_LAST) jam_hit[i] = 1'b1;
          end
        end
        RELEASE: begin
          if (sync_s[i]) begin
            state_d[i] = ACTIVE;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = IDLE;
            jcnt_d[i]  = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          state_d[i] = IDLE;
        end
      endcase
    end
  end

  // A same-edge pair is ambiguous, so both coins go back to the customer.
  always_comb begin
    both_ev = &ev;
    any_ev  = |ev;
    ev_code = ev[1] ? 2'b10 : 2'b01;
    pop     = !bus.hold && (count_q != 2'd0);
    full    = (count_q == 2'd2);
    drop    = any_ev && (both_ev || jam_q || (full && !pop));
    push    = any_ev && !drop;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ev_code;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      coin_q      <= 1'b0;
      coin_code_q <= 2'b00;
      reject_q    <= 1'b0;
      jam_q       <= 1'b0;
    end else begin
      coin_q      <= pop;
      coin_code_q <= pop ? mem[rd_ptr] : 2'b00;
      reject_q    <= drop;
      jam_q       <= jam_q | (|jam_hit);
    end
  end

  assign bus.coin    = coin_code_q;
  assign bus.reject  = reject_q;
  assign bus.jam     = jam_q;
  assign bus.pending = count_q;
  assign dbg_state5  = state_q[0];
  assign dbg_state10 = state_q[1];

  a_count_range : assert property (@(posedge clk) disable iff (reset)
    count_q != 2'd3);
  a_coin_code : assert property (@(posedge clk) disable iff (reset)
    coin_code_q != 2'b11);
  a_coin_valid : assert property (@(posedge clk) disable iff (reset)
    coin_q == (coin_code_q != 2'b00));
endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: stimulus pushes expected coins and
// rejects into queues that a negedge monitor pops and compares.
module tb_coin_acceptor;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state5;
  logic [1:0] dbg_state10;

  coin_acceptor_if bus();

  coin_acceptor #(.DEB_CYCLES(4), .JAM_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dbg_state5 (dbg_state5),
    .dbg_state10(dbg_state10)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [1:0] exp_q[$];
  logic [0:0] rej_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    chk_cnt++;
    $display("FAIL %s: got %0d expected nothing", name, act);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input bit ch10, input int hi, input int lo);
    if (ch10) bus.sense10 = 1'b1;
    else      bus.sense5  = 1'b1;
    wait_cycles(hi);
    bus.sense5  = 1'b0;
    bus.sense10 = 1'b0;
    wait_cycles(lo);
  endtask

  // Monitor: each emitted coin and each reject pulse consumes one expectation.
  always @(negedge clk) begin
    if (bus.coin != 2'b00) begin
      if (exp_q.size() == 0) unexpected("coin_sb", {30'd0, bus.coin});
      else check("coin_sb", {30'd0, bus.coin}, {30'd0, exp_q.pop_front()});
    end
    if (bus.reject) begin
      if (rej_q.size() == 0) unexpected("reject_sb", 32'd1);
      else check("reject_jam_sb", {31'd0, bus.jam}, {31'd0, rej_q.pop_front()});
    end
  end

  initial begin
    bus.sense5  = 1'b0;
    bus.sense10 = 1'b0;
    bus.hold    = 1'b0;
    reset       = 1'b1;
    wait_cycles(3);
    check("rst_coin", {30'd0, bus.coin}, 32'd0);
    check("rst_reject", {31'd0, bus.reject}, 32'd0);
    check("rst_jam", {31'd0, bus.jam}, 32'd0);
    check("rst_pending", {30'd0, bus.pending}, 32'd0);
    check("rst_state5", {30'd0, dbg_state5}, 32'd0);
    check("rst_state10", {30'd0, dbg_state10}, 32'd0);
    reset = 1'b0;
    wait_cycles(2);

    // Clean insertion: event written at edge 5, coin visible after edge 6 only.
    exp_q.push_back(2'b01);
    bus.sense5 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("clean_coin", {30'd0, bus.coin}, (k == 6) ? 32'd1 : 32'd0);
      if (k == 5) check("clean_pending_e5", {30'd0, bus.pending}, 32'd1);
      if (k == 6) check("clean_pending_e6", {30'd0, bus.pending}, 32'd0);
    end
    bus.sense5 = 1'b0;
    wait_cycles(12);
    check("clean_pending_end", {30'd0, bus.pending}, 32'd0);

    // Bounce: short highs fall back to idle, final long high yields one coin.
    exp_q.push_back(2'b10);
    for (int r = 0; r < 3; r++) pulse(1'b1, 2, 1);
    pulse(1'b1, 8, 15);
    pulse(1'b1, 3, 3);
    pulse(1'b0, 3, 3);
    pulse(1'b1, 3, 12);
    check("bounce_pending", {30'd0, bus.pending}, 32'd0);

    // Hold and overflow: third coin rejected while the queue is full.
    bus.hold = 1'b1;
    exp_q.push_back(2'b01);
    pulse(1'b0, 8, 12);
    check("hold_pending_1", {30'd0, bus.pending}, 32'd1);
    exp_q.push_back(2'b10);
    pulse(1'b1, 8, 12);
    check("hold_pending_2", {30'd0, bus.pending}, 32'd2);
    rej_q.push_back(1'b0);
    pulse(1'b0, 8, 12);
    check("hold_pending_3", {30'd0, bus.pending}, 32'd2);
    check("hold_coin_idle", {30'd0, bus.coin}, 32'd0);
    bus.hold = 1'b0;
    @(negedge clk);
    check("drain_coin_1", {30'd0, bus.coin}, 32'd1);
    check("drain_pending_1", {30'd0, bus.pending}, 32'd1);
    @(negedge clk);
    check("drain_coin_2", {30'd0, bus.coin}, 32'd2);
    check("drain_pending_2", {30'd0, bus.pending}, 32'd0);
    @(negedge clk);
    check("drain_coin_3", {30'd0, bus.coin}, 32'd0);
    wait_cycles(5);

    // Simultaneous events on both channels.
    rej_q.push_back(1'b0);
    bus.sense5  = 1'b1;
    bus.sense10 = 1'b1;
    wait_cycles(8);
    bus.sense5  = 1'b0;
    bus.sense10 = 1'b0;
    wait_cycles(12);
    check("simul_pending", {30'd0, bus.pending}, 32'd0);
    check("simul_jam", {31'd0, bus.jam}, 32'd0);

    // Jam: stuck sensor accepted once, jam raised after 16 active-high edges.
    exp_q.push_back(2'b01);
    bus.sense5 = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      check("jam_flag", {31'd0, bus.jam}, (k >= 21) ? 32'd1 : 32'd0);
    end
    bus.sense5 = 1'b0;
    wait_cycles(12);
    rej_q.push_back(1'b1);
    pulse(1'b1, 8, 12);
    check("jam_pending", {30'd0, bus.pending}, 32'd0);
    check("jam_sticky", {31'd0, bus.jam}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("jam_cleared", {31'd0, bus.jam}, 32'd0);
    wait_cycles(3);

    // Reset mid-queue: queued coins vanish without a reject.
    bus.hold = 1'b1;
    pulse(1'b0, 8, 12);
    pulse(1'b1, 8, 12);
    check("midq_pending_pre", {30'd0, bus.pending}, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midq_pending_post", {30'd0, bus.pending}, 32'd0);
    check("midq_reject", {31'd0, bus.reject}, 32'd0);
    bus.hold = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("midq_coin", {30'd0, bus.coin}, 32'd0);
    end

    check("exp_q_empty", exp_q.size(), 32'd0);
    check("rej_q_empty", rej_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
